// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared widths, tdata field layout and helpers for the accumulator readout path
package accum_pkg;

  localparam int ACC_WIDTH   = 48;
  localparam int TDATA_WIDTH = 64;
  localparam int CH_FIELD    = 8;

  // tdata layout: {channel index, zero pad, accumulator result}
  localparam int CH_LSB   = 56;
  localparam int DATA_LSB = 0;

  typedef logic [TDATA_WIDTH-1:0] tdata_t;

  // Ceiling log2, used to size channel index fields from the channel count.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_readout_sched_rr_arbiter.sv
// rtl/accum_readout_sched_rr_arbiter.sv - combinational round-robin arbiter, searches cyclically after the last grant
module rr_arbiter
  import accum_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int CH_WIDTH = clog2(N_CH)
) (
  input  logic [N_CH-1:0]     req,
  input  logic [CH_WIDTH-1:0] last,
  output logic [N_CH-1:0]     gnt_onehot,
  output logic [CH_WIDTH-1:0] gnt_idx,
  output logic                any
);

  logic [CH_WIDTH-1:0] cand;

  // Walk channels last+1, last+2, ... wrapping; the first requester found wins.
  // Offset N_CH revisits 'last' itself so a lone requester on the last-granted
  // channel is still served.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int off = 1; off <= N_CH; off++) begin
      cand = CH_WIDTH'((int'(last) + off) % N_CH);
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_readout_sched.sv
// rtl/accum_readout_sched.sv - serialises per-channel accumulator results onto one AXI4-Stream master
module accum_readout_sched
  import accum_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int ACC_WIDTH = accum_pkg::ACC_WIDTH,
  parameter int CH_WIDTH  = clog2(N_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             acc_valid,
  input  logic [N_CH*ACC_WIDTH-1:0]   acc_data,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [TDATA_WIDTH-1:0]      m_tdata,
  output logic                        m_tlast,
  output logic [N_CH-1:0]             ovf,
  input  logic                        ovf_clr,
  output logic [31:0]                 word_cnt
);

  logic [ACC_WIDTH-1:0]   hold_q [N_CH];
  logic [N_CH-1:0]        pend_q, pend_d;
  logic [N_CH-1:0]        ovf_q, ovf_d;
  logic [N_CH-1:0]        take;
  logic [CH_WIDTH-1:0]    ptr_q;
  logic [N_CH-1:0]        gnt_onehot;
  logic [CH_WIDTH-1:0]    gnt_idx;
  logic                   gnt_any;
  logic                   load;
  logic                   m_tvalid_q;
  tdata_t                 m_tdata_q, m_tdata_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [31:0]            word_cnt_q;

  rr_arbiter #(
    .N_CH     (N_CH),
    .CH_WIDTH (CH_WIDTH)
  ) u_arb (
    .req        (pend_q),
    .last       (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // The output register may take a new beat when empty or when its current beat is being accepted.
  assign load = !m_tvalid_q | m_tready;
  assign take = (load && gnt_any) ? gnt_onehot : '0;

  // Pending/overflow next state: a fresh capture always re-arms pend, and only counts
  // as a drop when the old value is not leaving through the output this cycle.
  always_comb begin
    pend_d = acc_valid | (pend_q & ~take);
    ovf_d  = (ovf_q & ~{N_CH{ovf_clr}}) | (acc_valid & pend_q & ~take);
  end

  // Format the granted channel's held result into the outgoing word.
  always_comb begin
    m_tdata_d                            = '0;
    m_tdata_d[CH_LSB +: CH_FIELD]        = CH_FIELD'(gnt_idx);
    m_tdata_d[DATA_LSB +: ACC_WIDTH]     = hold_q[gnt_idx];
    m_tlast_d                            = (gnt_idx == CH_WIDTH'(N_CH - 1));
  end

  // Per-channel holding slots; newest capture always wins, the output reads the pre-edge value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (acc_valid[i]) begin
        hold_q[i] <= acc_data[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // Control state: pending/overflow flags, round-robin pointer, output register and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q     <= '0;
      ovf_q      <= '0;
      ptr_q      <= CH_WIDTH'(N_CH - 1);
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (m_tvalid_q && m_tready) begin
        word_cnt_q <= word_cnt_q + 32'd1;
      end
      if (load) begin
        if (gnt_any) begin
          m_tvalid_q <= 1'b1;
          m_tdata_q  <= m_tdata_d;
          m_tlast_q  <= m_tlast_d;
          ptr_q      <= gnt_idx;
        end else begin
          m_tvalid_q <= 1'b0;
        end
      end
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tlast  = m_tlast_q;
  assign ovf      = ovf_q;
  assign word_cnt = word_cnt_q;

endmodule
